// File: rtl/led_breathe_pwm_if.sv
// led_breathe_pwm_if: step/enable inputs and LED/level/phase outputs
// master drives TICK/EN; slave (the breather) drives LED/DUTY/PHASE
interface led_breathe_pwm_if #(
  parameter int PWM_WIDTH = 8
);
  logic                 TICK;
  logic                 EN;
  logic                 LED;
  logic [PWM_WIDTH-1:0] DUTY;
  logic [1:0]           PHASE;

  modport master (
    output TICK, EN,
    input  LED, DUTY, PHASE
  );

  modport slave (
    input  TICK, EN,
    output LED, DUTY, PHASE
  );
endinterface

// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: triangle "breathing" LED level stepped by TICK,
// rendered by a glitch-free PWM.
// Ports:
//   CLK, RESETN (sync, active-low),
//   bus.TICK, bus.EN, bus.LED, bus.DUTY, bus.PHASE.
// Macro BREATHE_HOLD_EN adds HOLD_HI/HOLD_LO dwell phases.
module led_breathe_pwm #(
  parameter int PWM_WIDTH  = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  led_breathe_pwm_if.slave bus
);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } phase_e;

  localparam logic [PWM_WIDTH-1:0] MAX =
    {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] ONE =
    PWM_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0] STEP_W =
    PWM_WIDTH'(STEP);
  // Turn-around threshold: avoids a wider DUTY+STEP sum.
  localparam logic [PWM_WIDTH-1:0] TOP =
    MAX - STEP_W;

  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] shadow;
  logic                 led_q;
  logic [PWM_WIDTH-1:0] duty_q;
  logic [PWM_WIDTH-1:0] duty_d;
  phase_e               phase_q;
  phase_e               phase_d;
  logic                 adv;

  assign adv = bus.TICK & bus.EN;

`ifdef BREATHE_HOLD_EN
  localparam int HW =
    (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  // PWM: shadow only reloads at period end, so
  // a DUTY change never truncates a period.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      led_q   <= 1'b0;
    end else begin
      led_q <= bus.EN & (pwm_cnt < shadow);
      if (pwm_cnt == MAX) begin
        shadow <= duty_q;
      end
      pwm_cnt <= bus.EN ? (pwm_cnt + ONE) : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      phase_q <= RISE;
      duty_q  <= '0;
    end else begin
      phase_q <= phase_d;
      duty_q  <= duty_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    duty_d  = duty_q;
`ifdef BREATHE_HOLD_EN
    hold_d  = hold_q;
`endif
    if (adv) begin
      case (phase_q)
        RISE: begin
          if (duty_q >= TOP) begin
            duty_d = MAX;
`ifdef BREATHE_HOLD_EN
            phase_d = HOLD_HI;
            hold_d  = '0;
`else
            phase_d = FALL;
`endif
          end else begin
            duty_d = duty_q + STEP_W;
          end
        end
        FALL: begin
          if (duty_q <= STEP_W) begin
            duty_d = '0;
`ifdef BREATHE_HOLD_EN
            phase_d = HOLD_LO;
            hold_d  = '0;
`else
            phase_d = RISE;
`endif
          end else begin
            duty_d = duty_q - STEP_W;
          end
        end
`ifdef BREATHE_HOLD_EN
        HOLD_HI: begin
          if (hold_q == HOLD_LAST) begin
            phase_d = FALL;
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
        HOLD_LO: begin
          if (hold_q == HOLD_LAST) begin
            phase_d = RISE;
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
`endif
        default: phase_d = RISE;
      endcase
    end
  end

  assign bus.LED   = led_q;
  assign bus.DUTY  = duty_q;
  assign bus.PHASE = phase_q;

endmodule

// File: doc/led_breathe_pwm.md
Name: led_breathe_pwm

Overview:
- Downstream consumer of the free-running 22-bit tick counter's carry-out pulse, COUT.
- Each TICK steps an LED brightness level up or down in a triangle "breathing" pattern.
- Renders that level on a single LED pin with a glitch-free PWM generator clocked directly by CLK.
- Replaces the raw counter-MSB blink on the board LED output.

Parameters:
- PWM_WIDTH, 8, width of the PWM counter and duty register; period = 2^PWM_WIDTH clocks.
- STEP, 1, duty increment/decrement per TICK; legal range 1..2^PWM_WIDTH-1.
- HOLD_TICKS, 16, number of TICKs spent in each hold phase; used only with the optional feature; must be >= 1.

Ports:
- CLK  input  1  system clock; all state is updated on the rising edge.
- RESETN  input  1  synchronous reset, active-low.
- TICK  input  1  one-cycle step pulse, driven from the counter COUT.
- EN  input  1  run enable.
- LED  output  1  registered PWM output to the board LED.
- DUTY  output  PWM_WIDTH  current brightness level.
- PHASE  output  2  FSM state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO.

Behaviour:
- One clock domain. Reset is synchronous and active-low, sampled on the CLK rising edge.
- Reset values while RESETN=0: LED=0, DUTY=0, PHASE=0 (RISE), pwm_cnt=0, shadow duty=0, hold counter=0. TICK and EN are ignored during reset.
- Reset asserted mid-ramp or mid-hold takes effect at the next edge and overrides all other activity.
- PWM counter: pwm_cnt advances by 1 every CLK while EN=1 and wraps from 2^PWM_WIDTH-1 to 0.
- Shadow duty: loads DUTY only on the cycle where pwm_cnt = 2^PWM_WIDTH-1, so a duty change never takes effect mid-period.
- LED output: LED <= EN & (pwm_cnt < shadow). Latency is one cycle from pwm_cnt to LED.
  - shadow = 0 gives LED constantly 0.
  - shadow = MAX gives MAX high cycles per period.
  - MAX = 2^PWM_WIDTH-1.
- FSM advances only on cycles with TICK=1 and EN=1:
  - RISE: if DUTY >= MAX-STEP, then DUTY <= MAX and go to HOLD_HI (macro defined) or FALL. Otherwise DUTY <= DUTY+STEP.
  - FALL: if DUTY <= STEP, then DUTY <= 0 and go to HOLD_LO (macro defined) or RISE. Otherwise DUTY <= DUTY-STEP.
  - Arithmetic saturates; no wrap-around is permitted.
  - Width check: comparisons are against MAX-STEP (not DUTY+STEP) so no intermediate width beyond PWM_WIDTH is required.
- TICK on the same cycle as the pwm_cnt wrap: the shadow captures the pre-update DUTY. The new value is used from the following period.
- EN=0:
  - pwm_cnt is held at 0 and LED is 0 from the next cycle.
  - DUTY, PHASE and the hold counter are frozen; TICKs are ignored.
  - When EN returns to 1, counting resumes with pwm_cnt=0.
- TICK pulses longer than one cycle count once per cycle high; no edge detection is performed.

Optional Feature:
- Macro: BREATHE_HOLD_EN.
- Defined:
  - HOLD_HI and HOLD_LO are live states.
  - On entry the hold counter is cleared; it increments on each TICK.
  - On the TICK where the hold counter = HOLD_TICKS-1, HOLD_HI goes to FALL and HOLD_LO goes to RISE.
  - DUTY is unchanged while holding.
- Undefined:
  - No hold counter or hold states are built.
  - PHASE only takes values 0 and 2.
  - HOLD_TICKS is ignored.

Test Plan:
- Reset: PWM_WIDTH=4, STEP=4, EN=1, RESETN=0 for 3 cycles with TICK toggling -> LED=0, DUTY=0, PHASE=0 throughout and on the cycle after release.
- Ramp/turn, macro undefined, PWM_WIDTH=4, STEP=4:
  - 4 TICKs -> DUTY 4, 8, 12, 15; PHASE=2 after the 4th.
  - 4 more TICKs -> DUTY 11, 7, 3, 0; PHASE=0.
- PWM accuracy: DUTY=8 latched -> each 16-cycle period has LED high for exactly 8 consecutive cycles (pwm_cnt 0..7), lagging pwm_cnt by 1 cycle. DUTY=15 -> 15 high, 1 low. DUTY=0 -> always low.
- Wrap collision: TICK coincides with pwm_cnt=15 while DUTY 4->8 -> the next period has 4 high cycles and the period after has 8.
- Enable: EN=0 mid-ramp at DUTY=8 for 40 cycles with 3 TICKs -> LED=0 from the next cycle, DUTY stays 8. On re-enable, the first period has 8 high cycles starting at pwm_cnt=0.
- Hold, BREATHE_HOLD_EN defined, HOLD_TICKS=2, STEP=4:
  - TICK reaching 15 -> PHASE=1.
  - 2 TICKs -> DUTY stays 15, then PHASE=2.
  - Next TICK -> DUTY=11.
